// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: synchronizes an asynchronous spike level, counts rising
// edges over a programmable window, and reports the last window count, the sum
// of the last four window counts and a free-running total of counted spikes.
module spike_rate_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             rawclk,
  input  logic             reset_global,
  input  logic             en,
  input  logic             spike,
  input  logic [31:0]      window_len,
  output logic [CNT_W-1:0] spike_count_out,
  output logic [CNT_W+1:0] avg4_out,
  output logic [31:0]      total_out,
  output logic             count_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2, s3;
  logic             rise;
  logic [31:0]      eff_len;
  logic [31:0]      win_cnt;
  logic             close;
  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   acc_sum;
  logic             acc_sat;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W+1:0] avg_next;
  logic [CNT_W-1:0] hist [4];

  // Edge detect, effective window length, close decision and saturating sum
  always_comb begin
    rise     = s2 & ~s3;
    eff_len  = (window_len == 32'd0) ? 32'd1 : window_len;
    close    = en && (win_cnt >= (eff_len - 32'd1));
    acc_sum  = {1'b0, acc} + {{CNT_W{1'b0}}, rise};
    acc_sat  = acc_sum[CNT_W];
    acc_next = acc_sat ? CNT_MAX : acc_sum[CNT_W-1:0];
    avg_next = {2'b00, acc_next} + {2'b00, hist[0]} + {2'b00, hist[1]}
             + {2'b00, hist[2]};
  end

  // Two-flop synchronizer plus delay flop; runs whether or not counting is enabled
  always_ff @(posedge rawclk) begin
    if (reset_global) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= spike;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Window counting, close handling, history shift and running total
  always_ff @(posedge rawclk) begin
    if (reset_global) begin
      win_cnt         <= '0;
      acc             <= '0;
      spike_count_out <= '0;
      avg4_out        <= '0;
      total_out       <= '0;
      count_valid     <= 1'b0;
      overflow        <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      count_valid <= 1'b0;
      if (en) begin
        total_out <= total_out + {31'd0, rise};
        if (rise && acc_sat) overflow <= 1'b1;
        if (close) begin
          win_cnt         <= '0;
          acc             <= '0;
          spike_count_out <= acc_next;
          avg4_out        <= avg_next;
          count_valid     <= 1'b1;
          hist[0]         <= acc_next;
          for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end else begin
          win_cnt <= win_cnt + 32'd1;
          acc     <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed testbench for spike_rate_decoder with hand-computed expectations.
module tb_spike_rate_decoder;

  logic        rawclk = 1'b0;
  logic        reset_global = 1'b1;
  logic        en = 1'b0;
  logic        spike = 1'b0;
  logic [31:0] window_len = 32'd0;

  logic [15:0] spike_count_out;
  logic [17:0] avg4_out;
  logic [31:0] total_out;
  logic        count_valid;
  logic        overflow;

  logic [3:0]  sc_small;
  logic [5:0]  avg_small;
  logic [31:0] total_small;
  logic        valid_small;
  logic        ovf_small;

  int checks = 0;
  int failures = 0;
  int vcnt;
  int vfirst;
  logic [31:0] saved_total;
  logic [15:0] saved_count;
  int hist_counts [5] = '{3, 7, 0, 2, 1};

  always #5 rawclk = ~rawclk;

  spike_rate_decoder #(.CNT_W(16)) dut (
    .rawclk(rawclk), .reset_global(reset_global), .en(en), .spike(spike),
    .window_len(window_len), .spike_count_out(spike_count_out),
    .avg4_out(avg4_out), .total_out(total_out), .count_valid(count_valid),
    .overflow(overflow)
  );

  spike_rate_decoder #(.CNT_W(4)) dut_small (
    .rawclk(rawclk), .reset_global(reset_global), .en(en), .spike(spike),
    .window_len(window_len), .spike_count_out(sc_small),
    .avg4_out(avg_small), .total_out(total_small), .count_valid(valid_small),
    .overflow(ovf_small)
  );

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge rawclk);
    #1;
  endtask

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive n pulses (high cycles out of every period) over a number of cycles,
  // recording how many count_valid pulses appear and the cycle of the first
  task automatic applyStimulus(input int n, input int high, input int period,
                               input int cycles, output int valid_cnt,
                               output int first_valid);
    valid_cnt = 0;
    first_valid = 0;
    for (int c = 1; c <= cycles; c++) begin
      spike = (((c - 1) % period) < high) && (((c - 1) / period) < n);
      tick();
      if (count_valid) begin
        valid_cnt++;
        if (first_valid == 0) first_valid = c;
      end
    end
    spike = 1'b0;
  endtask

  // Hold reset with en=1 and window_len=0 (would close every cycle) and check it wins
  task automatic doReset(input logic hold_spike, input logic [31:0] len);
    reset_global = 1'b1;
    en = 1'b1;
    window_len = 32'd0;
    spike = hold_spike;
    tick();
    tick();
    tick();
    checkOutput("rst_valid", {63'd0, count_valid}, 64'd0);
    checkOutput("rst_count", {48'd0, spike_count_out}, 64'd0);
    checkOutput("rst_avg", {46'd0, avg4_out}, 64'd0);
    checkOutput("rst_total", {32'd0, total_out}, 64'd0);
    checkOutput("rst_ovf", {63'd0, overflow}, 64'd0);
    reset_global = 1'b0;
    window_len = len;
    en = 1'b1;
  endtask

  initial begin
    // Spike held high across reset release counts once, on the third edge
    doReset(1'b1, 32'd100);
    tick();
    tick();
    checkOutput("hold_total_e2", {32'd0, total_out}, 64'd0);
    tick();
    checkOutput("hold_total_e3", {32'd0, total_out}, 64'd1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("hold_total_later", {32'd0, total_out}, 64'd1);
    spike = 1'b0;

    // Basic window: 5 spikes of 4 cycles, 10 apart, window of 100
    doReset(1'b0, 32'd100);
    applyStimulus(5, 4, 10, 100, vcnt, vfirst);
    checkOutput("basic_first_valid", 64'(vfirst), 64'd100);
    checkOutput("basic_valid_cnt", 64'(vcnt), 64'd1);
    checkOutput("basic_count", {48'd0, spike_count_out}, 64'd5);
    checkOutput("basic_total", {32'd0, total_out}, 64'd5);
    checkOutput("basic_avg", {46'd0, avg4_out}, 64'd5);
    checkOutput("basic_ovf", {63'd0, overflow}, 64'd0);
    tick();
    checkOutput("basic_valid_drop", {63'd0, count_valid}, 64'd0);

    // History: counts 3,7,0,2 then 1
    doReset(1'b0, 32'd40);
    for (int w = 0; w < 5; w++) begin
      applyStimulus(hist_counts[w], 2, 4, 40, vcnt, vfirst);
      checkOutput("hist_valid_cnt", 64'(vcnt), 64'd1);
      checkOutput("hist_count", {48'd0, spike_count_out}, 64'(hist_counts[w]));
      if (w == 3) checkOutput("hist_avg4", {46'd0, avg4_out}, 64'd12);
      if (w == 4) checkOutput("hist_avg5", {46'd0, avg4_out}, 64'd10);
    end
    checkOutput("hist_total", {32'd0, total_out}, 64'd13);

    // Saturation: 20 spikes in a 1000-cycle window, 4-bit and 16-bit instances
    doReset(1'b0, 32'd1000);
    applyStimulus(20, 2, 4, 1000, vcnt, vfirst);
    checkOutput("sat_first_valid", 64'(vfirst), 64'd1000);
    checkOutput("sat_small_count", {60'd0, sc_small}, 64'd15);
    checkOutput("sat_small_ovf", {63'd0, ovf_small}, 64'd1);
    checkOutput("sat_small_total", {32'd0, total_small}, 64'd20);
    checkOutput("sat_small_avg", {58'd0, avg_small}, 64'd15);
    checkOutput("sat_wide_count", {48'd0, spike_count_out}, 64'd20);
    checkOutput("sat_wide_ovf", {63'd0, overflow}, 64'd0);
    applyStimulus(0, 2, 4, 20, vcnt, vfirst);
    checkOutput("sat_small_ovf_sticky", {63'd0, ovf_small}, 64'd1);

    // Rise synchronized on the close edge counts in the closing window
    doReset(1'b0, 32'd8);
    for (int c = 1; c <= 8; c++) begin
      spike = (c >= 6);
      tick();
      if (c == 7) checkOutput("edge_valid_c7", {63'd0, count_valid}, 64'd0);
    end
    checkOutput("edge_valid_c8", {63'd0, count_valid}, 64'd1);
    checkOutput("edge_count", {48'd0, spike_count_out}, 64'd1);
    applyStimulus(0, 2, 4, 8, vcnt, vfirst);
    checkOutput("edge_next_first", 64'(vfirst), 64'd8);
    checkOutput("edge_next_count", {48'd0, spike_count_out}, 64'd0);
    checkOutput("edge_total", {32'd0, total_out}, 64'd1);

    // window_len=0 closes every cycle; en=0 freezes everything
    doReset(1'b0, 32'd0);
    applyStimulus(2, 2, 4, 10, vcnt, vfirst);
    checkOutput("len0_valid_cnt", 64'(vcnt), 64'd10);
    checkOutput("len0_first", 64'(vfirst), 64'd1);
    checkOutput("len0_total", {32'd0, total_out}, 64'd2);
    saved_total = total_out;
    saved_count = spike_count_out;
    en = 1'b0;
    applyStimulus(10, 2, 4, 50, vcnt, vfirst);
    checkOutput("dis_valid_cnt", 64'(vcnt), 64'd0);
    checkOutput("dis_total", {32'd0, total_out}, {32'd0, saved_total});
    checkOutput("dis_count", {48'd0, spike_count_out}, {48'd0, saved_count});

    // en=0 pauses the window counter
    doReset(1'b0, 32'd20);
    applyStimulus(0, 2, 4, 10, vcnt, vfirst);
    en = 1'b0;
    applyStimulus(0, 2, 4, 10, vcnt, vfirst);
    checkOutput("pause_valid_cnt", 64'(vcnt), 64'd0);
    en = 1'b1;
    applyStimulus(0, 2, 4, 10, vcnt, vfirst);
    checkOutput("pause_resume_first", 64'(vfirst), 64'd10);

    // Shrinking window_len mid-window closes on the next edge
    doReset(1'b0, 32'd100);
    applyStimulus(0, 2, 4, 30, vcnt, vfirst);
    checkOutput("shrink_before", 64'(vcnt), 64'd0);
    window_len = 32'd10;
    applyStimulus(0, 2, 4, 1, vcnt, vfirst);
    checkOutput("shrink_close", 64'(vcnt), 64'd1);

    // Reset mid-window discards the partial count
    doReset(1'b0, 32'd100);
    applyStimulus(2, 2, 4, 100, vcnt, vfirst);
    checkOutput("mid_prev_count", {48'd0, spike_count_out}, 64'd2);
    applyStimulus(3, 2, 4, 40, vcnt, vfirst);
    checkOutput("mid_total_pre", {32'd0, total_out}, 64'd5);
    reset_global = 1'b1;
    tick();
    checkOutput("mid_rst_count", {48'd0, spike_count_out}, 64'd0);
    checkOutput("mid_rst_total", {32'd0, total_out}, 64'd0);
    checkOutput("mid_rst_avg", {46'd0, avg4_out}, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, count_valid}, 64'd0);
    reset_global = 1'b0;
    applyStimulus(0, 2, 4, 100, vcnt, vfirst);
    checkOutput("mid_next_first", 64'(vfirst), 64'd100);
    checkOutput("mid_next_count", {48'd0, spike_count_out}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-window spike count.
REQ-002 SHALL have port rawclk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_global, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1: counting enable.
REQ-005 SHALL have port spike, input, 1: spike level from the neuron pool, asynchronous to rawclk.
REQ-006 SHALL have port window_len, input, 32: window length in rawclk cycles.
REQ-007 SHALL have port spike_count_out, output, CNT_W: spike count of the last closed window.
REQ-008 SHALL have port avg4_out, output, CNT_W+2: sum of the last four closed-window counts.
REQ-009 SHALL have port total_out, output, 32: running total of counted spikes.
REQ-010 SHALL have port count_valid, output, 1: one-cycle pulse marking a window close.
REQ-011 SHALL have port overflow, output, 1: sticky saturation flag.

Function
REQ-012 SHALL pass spike through a 2-flop synchronizer (s1, s2) followed by a delay flop s3; a counted edge is rise = s2 & ~s3.
REQ-013 SHALL register rise on the third rawclk edge after spike goes high, provided spike stays high for at least 2 cycles.
REQ-014 SHALL keep the synchronizer running regardless of en.
REQ-015 SHALL treat window_len = 0 as 1; effective length L = max(window_len, 1).
REQ-016 With en=1, SHALL increment win_cnt each cycle and add rise to accumulator acc.
REQ-017 SHALL close the window on the cycle win_cnt >= L-1, including a shrink of window_len mid-window.
REQ-018 On window close: win_cnt<=0, acc<=0, spike_count_out<=sat(acc+rise), and count_valid=1 on the same edge.
REQ-019 A rise coincident with window close SHALL count in the closing window.
REQ-020 count_valid SHALL be 0 in every cycle other than the one following a close edge.
REQ-021 acc and the closing value SHALL saturate at 2^CNT_W-1.
REQ-022 overflow SHALL set on any saturating increment and clear only on reset.
REQ-023 SHALL hold a 4-entry history h0..h3 that shifts on each close; h0 <= the new count.
REQ-024 On the close edge, avg4_out SHALL become new count + h0 + h1 + h2 (pre-shift values), CNT_W+2 bits, with no overflow possible.
REQ-025 total_out SHALL increment by 1 per counted rise while en=1 and wrap modulo 2^32, independent of windows and saturation.
REQ-026 With en=0: win_cnt, acc and total_out hold, rises are discarded, and no window closes.
REQ-027 spike_count_out, avg4_out and overflow SHALL hold between closes.

Reset
REQ-028 On reset_global=1 at a rawclk edge, SHALL clear all outputs, win_cnt, acc, h0..h3, s1, s2 and s3 to 0.
REQ-029 Reset SHALL override en and any coincident window close.
REQ-030 A spike held high across reset release SHALL count as exactly one rise, 3 cycles after release.
REQ-031 Reset mid-window SHALL discard the partial count; the next window starts at win_cnt=0 on the first cycle after release.

Verification
REQ-032 SHALL cover: window_len=100, en=1, 5 spikes of 4 cycles each, 10 cycles apart -> count_valid at cycle 100 after start, spike_count_out=5, total_out=5, avg4_out=5.
REQ-033 SHALL cover: four windows with counts 3,7,0,2 -> avg4_out=12; a fifth window of count 1 -> avg4_out=10.
REQ-034 SHALL cover: CNT_W=4, window_len=1000, 20 spikes -> spike_count_out=15, overflow=1, total_out=20.
REQ-035 SHALL cover: a rise synchronized on the close cycle, window_len=8 -> the rise counts in the closing window and the next window starts at 0.
REQ-036 SHALL cover: window_len=0 -> count_valid every cycle; en=0 for 50 cycles with spikes -> no count_valid and total_out unchanged.
REQ-037 SHALL cover: reset asserted at win_cnt=40 with acc=3 -> all outputs 0 next cycle, and the next close occurs L cycles after release.
